// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM encoding, forwarding selects and register-match helper
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int TIMEOUT_DEF = 16;
  // $0 is hardwired, so it never creates a dependency
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// hazard_ctrl_fwd_unit: combinational E-operand and D-branch-compare forwarding selects
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] wreg_m,
  input  logic [4:0] wreg_w,
  input  logic       rfwe_m,
  input  logic       rfwe_w,
  input  logic       mtorf_m,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d
);
  assign fwd_a_e = (rfwe_m && hit(wreg_m, rs_e)) ? FWD_MEM :
                   (rfwe_w && hit(wreg_w, rs_e)) ? FWD_WB : FWD_RF;
  assign fwd_b_e = (rfwe_m && hit(wreg_m, rt_e)) ? FWD_MEM :
                   (rfwe_w && hit(wreg_w, rt_e)) ? FWD_WB : FWD_RF;
  // a load in M has no ALU result to offer the branch comparator
  assign fwd_a_d = rfwe_m && !mtorf_m && hit(wreg_m, rs_d);
  assign fwd_b_d = rfwe_m && !mtorf_m && hit(wreg_m, rt_d);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush priority, memory-wait FSM with timeout, and stall-cycle counter
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             pcsrc_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       wreg_e,
  input  logic [4:0]       wreg_m,
  input  logic [4:0]       wreg_w,
  input  logic             rfwe_e,
  input  logic             rfwe_m,
  input  logic             rfwe_w,
  input  logic             mtorf_e,
  input  logic             mtorf_m,
  input  logic             dmwe_m,
  input  logic             dm_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic [1:0]    a_e;
  logic [1:0]    b_e;
  logic          a_d;
  logic          b_d;
  logic          memwait;
  logic          hold;
  logic          dep_e;
  logic          dep_m;
  logic          dstall;

  hazard_ctrl_fwd_unit u_fwd (
    .rs_e(rs_e), .rt_e(rt_e), .rs_d(rs_d), .rt_d(rt_d),
    .wreg_m(wreg_m), .wreg_w(wreg_w),
    .rfwe_m(rfwe_m), .rfwe_w(rfwe_w), .mtorf_m(mtorf_m),
    .fwd_a_e(a_e), .fwd_b_e(b_e), .fwd_a_d(a_d), .fwd_b_d(b_d)
  );

  assign memwait  = (mtorf_m || dmwe_m) && !dm_ready && (state != ERR);
  assign hold     = (state == ERR) || memwait;
  assign dep_e    = hit(wreg_e, rs_d) || hit(wreg_e, rt_d);
  assign dep_m    = hit(wreg_m, rs_d) || hit(wreg_m, rt_d);
  assign dstall   = !hold && ((mtorf_e && dep_e) || (branch_d && ((rfwe_e && dep_e) || (mtorf_m && dep_m))));
  assign wait_nxt = wait_cnt + 1'b1;

  // every control output is forced quiet while reset is asserted
  assign stall_f = rst_n && (hold || dstall);
  assign stall_d = rst_n && (hold || dstall);
  assign stall_e = rst_n && hold;
  assign stall_m = rst_n && hold;
  assign flush_w = rst_n && hold;
  assign flush_e = rst_n && dstall;
  assign flush_d = rst_n && !hold && !dstall && (pcsrc_d || jump_d);
  assign fwd_a_e = rst_n ? a_e : FWD_RF;
  assign fwd_b_e = rst_n ? b_e : FWD_RF;
  assign fwd_a_d = rst_n && a_d;
  assign fwd_b_d = rst_n && b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (state == RUN && memwait) begin
        state    <= MEM_WAIT;
        wait_cnt <= '0;
      end else if (state == MEM_WAIT) begin
        if (!memwait) state <= RUN;
        else if (wait_nxt == WW'(TIMEOUT - 1)) begin
          state   <= ERR;
          mem_err <= 1'b1;
        end else wait_cnt <= wait_nxt;
      end
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and pipeline-sequencing controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Generates per-stage stall/flush enables and forwarding selects. Sequences multi-cycle data-memory accesses through a wait FSM with timeout detection.
- Keeps a saturating stall-cycle counter for debug.
- Sits beside the decoder and consumes the decoded RFWE/MtoRFSel/DMWE/Branch/Jump bits after they have been piped into each stage.

Parameters:
- TIMEOUT, 16, max cycles in MEM_WAIT before declaring a memory error.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_d, rt_d  in  5 each  source registers in decode.
- branch_d, jump_d  in  1 each  branch/jump decoded in D.
- pcsrc_d  in  1  branch taken (resolved in D).
- rs_e, rt_e  in  5 each  source registers in execute.
- wreg_e, wreg_m, wreg_w  in  5 each  destination register per stage (post RFDSel mux).
- rfwe_e, rfwe_m, rfwe_w  in  1 each  register-file write enable per stage.
- mtorf_e, mtorf_m  in  1 each  load (MtoRFSel) in E / M.
- dmwe_m  in  1  store in M.
- dm_ready  in  1  data memory completes the M-stage access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the pipeline register feeding that stage.
- flush_d, flush_e, flush_w  out  1 each  insert a bubble (zero control) into that stage.
- fwd_a_e, fwd_b_e  out  2 each  E operand select: 00 RF, 01 W result, 10 M ALU result.
- fwd_a_d, fwd_b_d  out  1 each  D branch-compare operand from the M ALU result.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  cycles with stall_f=1, saturating.

Behaviour:
- Register 0 never matches: no hazard and no forward when the compared register is 0.
- Forwarding (combinational), operand A:
  - fwd_a_e=10 if rfwe_m and wreg_m==rs_e.
  - else 01 if rfwe_w and wreg_w==rs_e.
  - else 00.
  - Operand B is identical using rt_e. M has priority over W.
- fwd_a_d=1 if rfwe_m and !mtorf_m and wreg_m==rs_d; fwd_b_d uses rt_d the same way.
- lwstall = mtorf_e and (wreg_e==rs_d or wreg_e==rt_d).
- brstall = branch_d and ((rfwe_e and wreg_e matches rs_d/rt_d) or (mtorf_m and wreg_m matches rs_d/rt_d)).
- memwait = (mtorf_m or dmwe_m) and !dm_ready, evaluated in RUN and MEM_WAIT.
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
  - RUN -> MEM_WAIT when memwait=1.
  - MEM_WAIT -> RUN on the cycle dm_ready=1.
  - MEM_WAIT -> ERR when wait_cnt reaches TIMEOUT-1 with dm_ready still 0. That transition sets mem_err.
  - ERR is terminal until reset.
- wait_cnt: cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle.
- Output priority, highest first:
  1. ERR, or memwait (state RUN or MEM_WAIT): stall_f/d/e/m=1, flush_w=1, all other flushes 0.
  2. lwstall or brstall: stall_f=stall_d=1, flush_e=1, flush_d=0.
  3. (pcsrc_d or jump_d): flush_d=1.
  4. Otherwise all stalls and flushes are 0.
- memwait is combinational on dm_ready, so a 1-cycle access with dm_ready=1 produces no stall.
- Simultaneous events:
  - memwait masks load-use, branch stall and flush_d.
  - Load-use and a taken jump in the same cycle: the stall wins, and the jump's flush_d is issued on the next unstalled cycle.
- stall_cnt increments on every cycle with stall_f=1 and saturates at all ones.
- Reset, asynchronous and valid mid-operation:
  - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
  - While rst_n=0, all stall/flush outputs are 0 and all fwd outputs are 0.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and forwarding-select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
- The TIMEOUT default also lives in the package.
- One natural sub-module, fwd_unit: the purely combinational forwarding compare.
- The FSM, counters and priority logic stay in hazard_ctrl.

Test Plan:
- Load-use:
  - Stimulus: lw to $8 in E (mtorf_e=1, wreg_e=8), rs_d=8.
  - Response: stall_f=stall_d=1 and flush_e=1 for exactly 1 cycle.
  - Following cycle with mtorf_m=1, wreg_m=8 and rs_e=8: fwd_a_e=01 once the load reaches W.
- Forward priority:
  - Stimulus: rfwe_m=1, wreg_m=5; rfwe_w=1, wreg_w=5; rs_e=5.
  - Response: fwd_a_e=10.
  - Repeat with wreg_m=0, wreg_w=0, rs_e=0: fwd_a_e=00.
- Branch hazard:
  - Stimulus: branch_d=1, rt_d=3, rfwe_e=1, wreg_e=3.
  - Response: 1-cycle stall.
  - Next cycle, rfwe_m=1, wreg_m=3, mtorf_m=0: fwd_b_d=1, no stall.
  - Then pcsrc_d=1 -> flush_d=1.
- Memory wait:
  - Stimulus: dmwe_m=1, dm_ready low for 3 cycles, then high.
  - Response: stall_f/d/e/m=1 and flush_w=1 for 3 cycles, release on the ready cycle, stall_cnt=3.
- Timeout:
  - Stimulus: mtorf_m=1, dm_ready held 0, TIMEOUT=16.
  - Response: mem_err=1 after 16 cycles and stalls held forever.
  - Asserting rst_n=0 mid-ERR clears everything asynchronously.
- Simultaneous events:
  - Stimulus: lwstall and jump_d=1 in the same cycle.
  - Response: flush_d=0 with the stall.
  - Next cycle, stall cleared and jump_d still 1: flush_d=1.
